// File: rtl/ecc_pkg.sv
// Shared definitions for the 16-bit data / 18-bit check codeword used by the
// block-2 decoder: widths, check-bit positions inside the syndrome, decode classes.
package ecc_pkg;

    localparam int DATA_W = 16;
    localparam int CHK_W  = 18;
    localparam int CW_W   = 34;

    // Bit positions of each check bit within in_cw[33:16] (and the syndrome)
    localparam int IDX_CA1 = 0;
    localparam int IDX_CA2 = 1;
    localparam int IDX_P1  = 2;
    localparam int IDX_D1  = 3;
    localparam int IDX_CB1 = 4;
    localparam int IDX_CB2 = 5;
    localparam int IDX_P2  = 6;
    localparam int IDX_D2  = 7;
    localparam int IDX_CC1 = 8;
    localparam int IDX_CC2 = 9;
    localparam int IDX_P3  = 10;
    localparam int IDX_D3  = 11;
    localparam int IDX_CD1 = 12;
    localparam int IDX_CD2 = 13;
    localparam int IDX_P4  = 14;
    localparam int IDX_D4  = 15;
    localparam int IDX_D5  = 16;
    localparam int IDX_D6  = 17;

    typedef logic [CHK_W-1:0]  syndrome_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        DEC_CLEAN,
        DEC_CHK_ONLY,
        DEC_CORR,
        DEC_UNCORR
    } dec_class_t;

    function automatic dec_class_t classify(syndrome_t syn, data_t mask);
        int         pc;
        dec_class_t res;
        pc = $countones(syn);
        if (syn == '0) begin
            res = DEC_CLEAN;
        end else if (pc == 1) begin
            res = DEC_CHK_ONLY;
        end else if ($onehot(mask) && (pc >= 2) && (pc <= 4)) begin
            res = DEC_CORR;
        end else begin
            res = DEC_UNCORR;
        end
        return res;
    endfunction

endpackage

// File: rtl/ecc_syndrome_gen.sv
// Combinational syndrome and single-bit flip mask for one received codeword.
module ecc_syndrome_gen
    import ecc_pkg::*;
(
    input  logic [CW_W-1:0]   cw,
    output logic [CHK_W-1:0]  syn,
    output logic [DATA_W-1:0] mask
);

    logic [DATA_W-1:0] x;
    logic [4:1]        a, b, c, d;
    logic [CHK_W-1:0]  calc;

    assign x = cw[DATA_W-1:0];
    // Group bit 4 is the lowest data bit of the nibble
    assign a = {x[0],  x[1],  x[2],  x[3]};
    assign b = {x[4],  x[5],  x[6],  x[7]};
    assign c = {x[8],  x[9],  x[10], x[11]};
    assign d = {x[12], x[13], x[14], x[15]};

    always_comb begin
        calc          = '0;
        calc[IDX_CA1] = a[2] ^ a[4];
        calc[IDX_CA2] = a[1] ^ a[3];
        calc[IDX_CB1] = b[2] ^ b[4];
        calc[IDX_CB2] = b[1] ^ b[3];
        calc[IDX_CC1] = c[2] ^ c[4];
        calc[IDX_CC2] = c[1] ^ c[3];
        calc[IDX_CD1] = d[2] ^ d[4];
        calc[IDX_CD2] = d[1] ^ d[3];
        calc[IDX_P1]  = a[1] ^ b[1] ^ c[1] ^ d[1];
        calc[IDX_P2]  = a[2] ^ b[2] ^ c[2] ^ d[2];
        calc[IDX_P3]  = a[3] ^ b[3] ^ c[3] ^ d[3];
        calc[IDX_P4]  = a[4] ^ b[4] ^ c[4] ^ d[4];
        calc[IDX_D1]  = a[1] ^ b[2] ^ c[1] ^ d[2];
        calc[IDX_D2]  = b[1] ^ a[2] ^ c[2] ^ d[1];
        calc[IDX_D3]  = a[3] ^ b[4] ^ c[3] ^ d[4];
        calc[IDX_D4]  = b[3] ^ a[4] ^ c[4] ^ d[3];
        calc[IDX_D5]  = a[2] ^ b[3] ^ c[2] ^ d[3];
        calc[IDX_D6]  = b[2] ^ a[3] ^ c[3] ^ d[2];
    end

    assign syn = cw[CW_W-1:DATA_W] ^ calc;

    // Row parity P_i picks the position, the group's odd/even column parity picks the group
    always_comb begin
        mask = '0;
        for (int i = 1; i <= 4; i++) begin
            mask[4 - i]  = syn[4*i - 2] & ((i % 2 == 1) ? syn[IDX_CA2] : syn[IDX_CA1]);
            mask[8 - i]  = syn[4*i - 2] & ((i % 2 == 1) ? syn[IDX_CB2] : syn[IDX_CB1]);
            mask[12 - i] = syn[4*i - 2] & ((i % 2 == 1) ? syn[IDX_CC2] : syn[IDX_CC1]);
            mask[16 - i] = syn[4*i - 2] & ((i % 2 == 1) ? syn[IDX_CD2] : syn[IDX_CD1]);
        end
    end

endmodule

// File: rtl/decoding_block2_pipe.sv
// Two-stage decoder: stage 1 holds data + syndrome, stage 2 holds the corrected
// word and flags; valid/ready on both sides plus saturating error counters.
module decoding_block2_pipe
    import ecc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [33:0]       in_cw,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic              out_corr,
    output logic              out_uncorr,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    logic [CHK_W-1:0]  in_syn;
    logic [DATA_W-1:0] in_mask;

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_x_q, s1_x_d;
    logic [CHK_W-1:0]  s1_syn_q, s1_syn_d;
    logic [DATA_W-1:0] s1_mask_q, s1_mask_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_corr_q, out_corr_d;
    logic              out_uncorr_q, out_uncorr_d;
    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

    logic              s1_advance;
    logic              out_fire;
    dec_class_t        s1_class;

    ecc_syndrome_gen u_syn (
        .cw   (in_cw),
        .syn  (in_syn),
        .mask (in_mask)
    );

    // Handshake: a transfer happens on any cycle where valid and ready are both high
    assign s1_advance = !s2_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s1_advance;
    assign out_fire   = s2_valid_q && out_ready;
    assign s1_class   = classify(s1_syn_q, s1_mask_q);

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_x_d       = s1_x_q;
        s1_syn_d     = s1_syn_q;
        s1_mask_d    = s1_mask_q;
        s2_valid_d   = s2_valid_q;
        out_data_d   = out_data_q;
        out_corr_d   = out_corr_q;
        out_uncorr_d = out_uncorr_q;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_x_d    = in_cw[DATA_W-1:0];
                s1_syn_d  = in_syn;
                s1_mask_d = in_mask;
            end
        end

        // Stage 2 only moves when its word is gone or leaving, so a stalled word stays put
        if (s1_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d   = (s1_class == DEC_CORR) ? (s1_x_q ^ s1_mask_q) : s1_x_q;
                out_corr_d   = (s1_class == DEC_CHK_ONLY) || (s1_class == DEC_CORR);
                out_uncorr_d = (s1_class == DEC_UNCORR);
            end
        end

        if (cnt_clr) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else begin
            if (out_fire && out_corr_q && (corr_cnt_q != '1)) begin
                corr_cnt_d = corr_cnt_q + 1'b1;
            end
            if (out_fire && out_uncorr_q && (uncorr_cnt_q != '1)) begin
                uncorr_cnt_d = uncorr_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_x_q       <= '0;
            s1_syn_q     <= '0;
            s1_mask_q    <= '0;
            s2_valid_q   <= 1'b0;
            out_data_q   <= '0;
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_x_q       <= s1_x_d;
            s1_syn_q     <= s1_syn_d;
            s1_mask_q    <= s1_mask_d;
            s2_valid_q   <= s2_valid_d;
            out_data_q   <= out_data_d;
            out_corr_q   <= out_corr_d;
            out_uncorr_q <= out_uncorr_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_data   = out_data_q;
    assign out_corr   = out_corr_q;
    assign out_uncorr = out_uncorr_q;
    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_decoding_block2_pipe.sv
// Self-checking bench for decoding_block2_pipe: directed codewords, stall and
// saturation scenarios, then randomized traffic against a behavioural decoder.
module tb_decoding_block2_pipe;

    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [33:0]       in_cw;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_data;
    logic              out_corr;
    logic              out_uncorr;
    logic              cnt_clr;
    logic [CNT_W-1:0]  corr_cnt;
    logic [CNT_W-1:0]  uncorr_cnt;

    int                checks  = 0;
    int                errors  = 0;
    int                emitted = 0;
    logic [17:0]       exp_q[$];
    logic [CNT_W-1:0]  m_corr   = '0;
    logic [CNT_W-1:0]  m_uncorr = '0;
    logic              prev_hold = 1'b0;
    logic [17:0]       prev_out  = '0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    decoding_block2_pipe #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cw      (in_cw),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_corr   (out_corr),
        .out_uncorr (out_uncorr),
        .cnt_clr    (cnt_clr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Which check bits data bit j participates in (group g = j/4, position i = 4 - j%4).
    function automatic logic [17:0] sig_of(input int j);
        logic [17:0] s;
        int          g;
        int          i;
        g = j / 4;
        i = 4 - (j % 4);
        s = '0;
        s[4*(i-1) + 2] = 1'b1;
        if (i % 2 == 1) s[4*g + 1] = 1'b1;
        else            s[4*g]     = 1'b1;
        if (g % 2 == 0) begin
            case (i)
                1: s[3] = 1'b1;
                2: begin s[7] = 1'b1; s[16] = 1'b1; end
                3: begin s[11] = 1'b1; s[17] = 1'b1; end
                default: s[15] = 1'b1;
            endcase
        end else begin
            case (i)
                1: s[7] = 1'b1;
                2: begin s[3] = 1'b1; s[17] = 1'b1; end
                3: begin s[15] = 1'b1; s[16] = 1'b1; end
                default: s[11] = 1'b1;
            endcase
        end
        return s;
    endfunction

    function automatic logic [17:0] calc_chk(input logic [15:0] x);
        logic [17:0] c;
        c = '0;
        for (int j = 0; j < 16; j++) if (x[j]) c = c ^ sig_of(j);
        return c;
    endfunction

    function automatic logic [33:0] encode(input logic [15:0] x);
        return {calc_chk(x), x};
    endfunction

    // Returns {data, corr, uncorr}
    function automatic logic [17:0] model(input logic [33:0] cw);
        logic [17:0] s;
        logic [15:0] mask;
        logic [15:0] data;
        logic        corr;
        logic        uncorr;
        int          pc;
        int          ones;
        int          g;
        int          i;
        s  = cw[33:16] ^ calc_chk(cw[15:0]);
        pc = 0;
        for (int k = 0; k < 18; k++) pc += int'(s[k]);
        mask = '0;
        ones = 0;
        for (int j = 0; j < 16; j++) begin
            g = j / 4;
            i = 4 - (j % 4);
            if (s[4*(i-1) + 2] && s[(i % 2 == 1) ? (4*g + 1) : (4*g)]) begin
                mask[j] = 1'b1;
                ones++;
            end
        end
        data   = cw[15:0];
        corr   = 1'b0;
        uncorr = 1'b0;
        if (pc == 0) begin
        end else if (pc == 1) begin
            corr = 1'b1;
        end else if (ones == 1 && pc <= 4) begin
            data = data ^ mask;
            corr = 1'b1;
        end else begin
            uncorr = 1'b1;
        end
        return {data, corr, uncorr};
    endfunction

    function automatic logic [33:0] make_word(input int nmin, input int nmax);
        logic [33:0] cw;
        logic [33:0] flipped;
        int          n;
        int          pos;
        cw      = encode(16'($urandom));
        flipped = '0;
        n       = int'($urandom_range(nmax, nmin));
        for (int k = 0; k < n; k++) begin
            pos = int'($urandom_range(33, 0));
            while (flipped[pos]) pos = int'($urandom_range(33, 0));
            flipped[pos] = 1'b1;
        end
        return cw ^ flipped;
    endfunction

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        logic [17:0] head;
        if (rst_n === 1'b1) begin
            check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
            check("corr_cnt", 32'(corr_cnt), 32'(m_corr));
            check("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
            if (prev_hold) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_word", 32'({out_data, out_corr, out_uncorr}), 32'(prev_out));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got word %0h expected no output", {out_data, out_corr, out_uncorr});
                end else begin
                    check("out_word", 32'({out_data, out_corr, out_uncorr}), 32'(exp_q[0]));
                end
            end
            head = '0;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                head = exp_q.pop_front();
                emitted++;
            end
            if (cnt_clr) begin
                m_corr   = '0;
                m_uncorr = '0;
            end else begin
                if (head[1] && m_corr != '1)   m_corr   = m_corr + 1'b1;
                if (head[0] && m_uncorr != '1) m_uncorr = m_uncorr + 1'b1;
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = {out_data, out_corr, out_uncorr};
            if (in_valid && in_ready) exp_q.push_back(model(in_cw));
        end else begin
            exp_q.delete();
            m_corr    = '0;
            m_uncorr  = '0;
            prev_hold = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    // Single word into an empty pipe; checks the two-cycle latency and the result.
    task automatic send_directed(input logic [33:0] cw, input string name,
                                 input logic [15:0] exp_data, input logic exp_c, input logic exp_u);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_cw     = cw;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_lat1"}, 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_data"}, 32'(out_data), 32'(exp_data));
        check({name, "_flags"}, 32'({out_corr, out_uncorr}), 32'({exp_c, exp_u}));
        tick();
    endtask

    // rdy_mode: 0 toggle 1010..., 1 always ready, 2 random
    task automatic run_traffic(input int nwords, input int rdy_mode, input int nmin, input int nmax,
                               input bit rand_valid, input bit rand_clr);
        int   sent;
        int   start;
        int   cyc;
        logic acc;
        sent  = 0;
        start = emitted;
        cyc   = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        while ((sent < nwords || emitted < start + nwords) && cyc < 5000) begin
            if (sent < nwords && !in_valid) begin
                if (!rand_valid || $urandom_range(3, 0) != 0) begin
                    in_valid = 1'b1;
                    in_cw    = make_word(nmin, nmax);
                end
            end
            case (rdy_mode)
                0:       out_ready = ~out_ready;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(1, 0));
            endcase
            cnt_clr = rand_clr && ($urandom_range(15, 0) == 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
            cyc++;
        end
        if (sent < nwords || emitted < start + nwords) begin
            checks++;
            errors++;
            $display("FAIL traffic_timeout: sent %0d emitted %0d required %0d", sent, emitted - start, nwords);
        end
        in_valid  = 1'b0;
        cnt_clr   = 1'b0;
        out_ready = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_cw     = '0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_word", 32'({out_data, out_corr, out_uncorr}), 32'd0);
        check("rst_counters", 32'({corr_cnt, uncorr_cnt}), 32'd0);
        tick();

        // Hand-encoded codewords pin the model's check-bit layout
        send_directed({18'h0C001, 16'h0001}, "pin_0001", 16'h0001, 1'b0, 1'b0);
        send_directed(encode(16'hA5C3), "clean_a5c3", 16'hA5C3, 1'b0, 1'b0);

        clear_counters();
        send_directed(encode(16'h1234) ^ (34'd1 << 5), "bit5_1234", 16'h1234, 1'b1, 1'b0);
        @(negedge clk);
        check("bit5_corr_cnt", 32'(corr_cnt), 32'd1);
        tick();

        send_directed({18'h00004, 16'hFFFF}, "p1_ffff", 16'hFFFF, 1'b1, 1'b0);

        clear_counters();
        send_directed({18'h00000, 16'h8001}, "dbl_0000", 16'h8001, 1'b0, 1'b1);
        @(negedge clk);
        check("dbl_uncorr_cnt", 32'(uncorr_cnt), 32'd1);
        check("dbl_corr_cnt", 32'(corr_cnt), 32'd0);
        tick();

        // Back-to-back words against a 1010... consumer
        run_traffic(8, 0, 0, 3, 1'b0, 1'b0);

        // Saturation at 4 bits
        clear_counters();
        run_traffic(20, 1, 1, 1, 1'b0, 1'b0);
        @(negedge clk);
        check("corr_sat", 32'(corr_cnt), 32'd15);
        tick();

        // Clear wins over a same-cycle correcting handshake
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_cw     = make_word(1, 1);
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        @(negedge clk);
        check("clr_hs_valid", 32'(out_valid), 32'd1);
        check("clr_hs_corr", 32'(out_corr), 32'd1);
        tick();
        cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_priority", 32'(corr_cnt), 32'd0);
        tick();

        // Reset in the middle of a burst
        run_traffic(4, 1, 1, 2, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_cw    = make_word(0, 2);
            tick();
        end
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_counters", 32'({corr_cnt, uncorr_cnt}), 32'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Randomized traffic, then full-rate streaming
        run_traffic(200, 2, 0, 3, 1'b1, 1'b1);
        run_traffic(50, 1, 0, 3, 1'b0, 1'b0);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
